// File: rtl/aud_pkg.sv
// Shared types and sizing helpers for the audio transport controller.
//   state_t    : encoded transport FSM state (exported on o_state)
//   key_t      : single key selected by the per-cycle key priority
//   slot_bits  : slot-index width for a given slot count (minimum 1)
//   slot_depth : words per slot for a given address width and slot count
package aud_pkg;

  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_IDLE       = 3'd1,
    ST_RECD       = 3'd2,
    ST_RECD_PAUSE = 3'd3,
    ST_PLAY       = 3'd4,
    ST_PLAY_PAUSE = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    KEY_NONE = 3'd0,
    KEY_STOP = 3'd1,
    KEY_REC  = 3'd2,
    KEY_PLAY = 3'd3,
    KEY_SLOT = 3'd4
  } key_t;

  function automatic int unsigned slot_bits(input int unsigned num_slots);
    return (num_slots <= 32'd2) ? 32'd1 : 32'($clog2(num_slots));
  endfunction

  function automatic int unsigned slot_depth(input int unsigned addr_w,
                                             input int unsigned num_slots);
    return 32'd1 << (addr_w - slot_bits(num_slots));
  endfunction

endpackage

// File: rtl/aud_sec_counter.sv
// Seconds counter: a prescaler counts enabled ticks up to a terminal count,
// then wraps and advances a saturating seconds value.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_tick         : sample strobe
//   i_enable       : ticks are counted only while high
//   i_clear        : synchronous clear of prescaler and seconds (wins over tick)
//   i_tc           : prescaler terminal count (samples per second - 1)
//   o_time         : registered seconds, saturates at all-ones
module aud_sec_counter #(
  parameter int unsigned PRESC_W = 15,
  parameter int unsigned TIME_W  = 6
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic               i_enable,
  input  logic               i_clear,
  input  logic [PRESC_W-1:0] i_tc,
  output logic [TIME_W-1:0]  o_time
);

  localparam logic [TIME_W-1:0] TIME_MAX = {TIME_W{1'b1}};

  logic [PRESC_W-1:0] presc_q;

  // Prescaler and saturating seconds value
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q <= '0;
      o_time  <= '0;
    end else if (i_clear) begin
      presc_q <= '0;
      o_time  <= '0;
    end else if (i_tick && i_enable) begin
      if (presc_q == i_tc) begin
        presc_q <= '0;
        if (o_time != TIME_MAX) o_time <= o_time + TIME_W'(1);
      end else begin
        presc_q <= presc_q + PRESC_W'(1);
      end
    end
  end

endmodule

// File: rtl/aud_transport_ctrl.sv
// Record/playback transport controller with slotted SRAM storage.
// SRAM is split into NUM_SLOTS equal slots, each with its own recorded length.
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_i2c_done              : codec init finished, leaves INIT
//   i_key_rec/play/stop/slot: 1-cycle key pulses (stop > rec > play > slot)
//   i_loop                  : loop playback at end of take
//   i_rec_valid, i_rec_data : recorder sample strobe and data
//   i_play_tick, i_play_off : DSP sample-consumed strobe and read offset
//   o_sram_*                : registered SRAM address/data/strobes (active low)
//   o_rec_*, o_dsp_*        : one-hot recorder / DSP controls decoded from state
//   o_dsp_restart           : 1-cycle rewind pulse on looped end of take
//   o_slot, o_slot_full     : selected slot and its full flag
//   o_state                 : encoded FSM state
//   o_rec_time, o_play_time : saturating seconds counters
module aud_transport_ctrl
  import aud_pkg::*;
#(
  parameter int unsigned ADDR_W          = 20,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned NUM_SLOTS       = 4,
  parameter int unsigned TIME_W          = 6,
  parameter int unsigned SAMPLES_PER_SEC = 32000,
  localparam int unsigned SLOT_BITS      = slot_bits(NUM_SLOTS),
  localparam int unsigned OFF_W          = ADDR_W - SLOT_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_i2c_done,
  input  logic                 i_key_rec,
  input  logic                 i_key_play,
  input  logic                 i_key_stop,
  input  logic                 i_key_slot,
  input  logic                 i_loop,
  input  logic                 i_rec_valid,
  input  logic [DATA_W-1:0]    i_rec_data,
  input  logic                 i_play_tick,
  input  logic [OFF_W-1:0]     i_play_off,
  output logic [ADDR_W-1:0]    o_sram_addr,
  output logic [DATA_W-1:0]    o_sram_wdata,
  output logic                 o_sram_we_n,
  output logic                 o_sram_oe_n,
  output logic                 o_rec_start,
  output logic                 o_rec_pause,
  output logic                 o_rec_stop,
  output logic                 o_dsp_start,
  output logic                 o_dsp_pause,
  output logic                 o_dsp_stop,
  output logic                 o_dsp_restart,
  output logic [SLOT_BITS-1:0] o_slot,
  output logic                 o_slot_full,
  output logic [2:0]           o_state,
  output logic [TIME_W-1:0]    o_rec_time,
  output logic [TIME_W-1:0]    o_play_time
);

  localparam int unsigned LEN_W      = OFF_W + 1;
  localparam int unsigned SLOT_DEPTH = slot_depth(ADDR_W, NUM_SLOTS);
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(SLOT_DEPTH);
  localparam logic [SLOT_BITS-1:0] SLOT_LAST = SLOT_BITS'(NUM_SLOTS - 1);
  localparam int unsigned PRESC_W =
    (SAMPLES_PER_SEC > 32'd1) ? 32'($clog2(SAMPLES_PER_SEC)) : 32'd1;
  localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(SAMPLES_PER_SEC - 1);

  state_t               state_q, state_d;
  key_t                 key;
  logic [SLOT_BITS-1:0] slot_q;
  logic [OFF_W-1:0]     wr_ptr_q;
  logic [LEN_W-1:0]     len_q [NUM_SLOTS];
  logic [LEN_W-1:0]     cur_len;
  logic                 cur_full;
  logic                 end_of_take;
  logic                 rec_active;
  logic                 wr_accept;
  logic                 rec_enter;
  logic                 play_enter;
  logic                 loop_restart;
  logic                 slot_inc;
  logic                 restart_q;

  assign cur_len     = len_q[slot_q];
  assign cur_full    = (cur_len == LEN_FULL);
  assign end_of_take = (LEN_W'(i_play_off) >= cur_len);
  // A full slot stops accepting strobes while the FSM heads back to IDLE
  assign rec_active  = (state_q == ST_RECD) && !cur_full;
  assign wr_accept   = rec_active && i_rec_valid;

  // Only the highest-priority key of the cycle is acted on
  always_comb begin
    key = KEY_NONE;
    if      (i_key_stop) key = KEY_STOP;
    else if (i_key_rec)  key = KEY_REC;
    else if (i_key_play) key = KEY_PLAY;
    else if (i_key_slot) key = KEY_SLOT;
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  // Next state and transition strobes
  always_comb begin
    state_d      = state_q;
    rec_enter    = 1'b0;
    play_enter   = 1'b0;
    loop_restart = 1'b0;
    slot_inc     = 1'b0;
    case (state_q)
      ST_INIT: if (i_i2c_done) state_d = ST_IDLE;
      ST_IDLE: begin
        case (key)
          KEY_REC: begin
            state_d   = ST_RECD;
            rec_enter = 1'b1;
          end
          KEY_PLAY: if (cur_len != '0) begin
            state_d    = ST_PLAY;
            play_enter = 1'b1;
          end
          KEY_SLOT: slot_inc = 1'b1;
          default: ;
        endcase
      end
      ST_RECD: begin
        if (key == KEY_STOP || cur_full) state_d = ST_IDLE;
        else if (key == KEY_REC)         state_d = ST_RECD_PAUSE;
      end
      ST_RECD_PAUSE: begin
        if (key == KEY_STOP)     state_d = ST_IDLE;
        else if (key == KEY_REC) state_d = ST_RECD;
      end
      ST_PLAY: begin
        if (key == KEY_STOP) begin
          state_d = ST_IDLE;
        end else if (end_of_take) begin
          if (i_loop) loop_restart = 1'b1;
          else        state_d      = ST_IDLE;
        end else if (key == KEY_PLAY) begin
          state_d = ST_PLAY_PAUSE;
        end
      end
      ST_PLAY_PAUSE: begin
        if (key == KEY_STOP)      state_d = ST_IDLE;
        else if (key == KEY_PLAY) state_d = ST_PLAY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Slot selection, write pointer and per-slot lengths
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_q   <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) len_q[i] <= '0;
    end else begin
      if (slot_inc) slot_q <= (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_BITS'(1);
      if (rec_enter) begin
        wr_ptr_q      <= '0;
        len_q[slot_q] <= '0;
      end else if (wr_accept) begin
        wr_ptr_q      <= wr_ptr_q + OFF_W'(1);
        len_q[slot_q] <= LEN_W'(wr_ptr_q) + LEN_W'(1);
      end
    end
  end

  // SRAM port, one cycle behind the accepted strobe / play offset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sram_addr  <= '0;
      o_sram_wdata <= '0;
      o_sram_we_n  <= 1'b1;
      o_sram_oe_n  <= 1'b1;
      restart_q    <= 1'b0;
    end else begin
      restart_q <= loop_restart;
      if (wr_accept) begin
        o_sram_addr  <= {slot_q, wr_ptr_q};
        o_sram_wdata <= i_rec_data;
        o_sram_we_n  <= 1'b0;
        o_sram_oe_n  <= 1'b1;
      end else if (state_q == ST_PLAY || state_q == ST_PLAY_PAUSE) begin
        o_sram_addr  <= {slot_q, i_play_off};
        o_sram_we_n  <= 1'b1;
        o_sram_oe_n  <= 1'b0;
      end else begin
        o_sram_we_n  <= 1'b1;
        o_sram_oe_n  <= 1'b1;
      end
    end
  end

  aud_sec_counter #(
    .PRESC_W (PRESC_W),
    .TIME_W  (TIME_W)
  ) u_rec_time (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_tick   (i_rec_valid),
    .i_enable (rec_active),
    .i_clear  (rec_enter),
    .i_tc     (PRESC_TC),
    .o_time   (o_rec_time)
  );

  // Looping rewinds the displayed play time along with the DSP
  aud_sec_counter #(
    .PRESC_W (PRESC_W),
    .TIME_W  (TIME_W)
  ) u_play_time (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_tick   (i_play_tick),
    .i_enable (state_q == ST_PLAY),
    .i_clear  (play_enter || loop_restart),
    .i_tc     (PRESC_TC),
    .o_time   (o_play_time)
  );

  assign o_rec_start   = (state_q == ST_RECD);
  assign o_rec_pause   = (state_q == ST_RECD_PAUSE);
  assign o_rec_stop    = !(o_rec_start || o_rec_pause);
  assign o_dsp_start   = (state_q == ST_PLAY);
  assign o_dsp_pause   = (state_q == ST_PLAY_PAUSE);
  assign o_dsp_stop    = !(o_dsp_start || o_dsp_pause);
  assign o_dsp_restart = restart_q;
  assign o_slot        = slot_q;
  assign o_slot_full   = cur_full;
  assign o_state       = state_q;

endmodule

// File: doc/aud_transport_ctrl.md
Name: aud_transport_ctrl

Overview:
Parametrised record/playback transport controller for the WM8731 audio path, driven by single-cycle key pulses. It partitions SRAM into NUM_SLOTS equal recording slots and keeps a per-slot recorded length. It generates the registered SRAM address, data and strobes, and drives the start/pause/stop controls for the recorder and DSP. Compared with the single-take controller, it adds slot selection, auto-stop when a slot is full, end-of-take detection with optional looping, and seconds-based time counters.

Parameters:
ADDR_W, 20, SRAM word-address width.
DATA_W, 16, sample width.
NUM_SLOTS, 4, number of recording slots; power of two, 1..16.
TIME_W, 6, width of the seconds counters; saturating.
SAMPLES_PER_SEC, 32000, sample strobes per displayed second.

Ports:
i_clk  in  1  BCLK-domain clock; all logic on rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_i2c_done  in  1  codec initialisation finished (level).
i_key_rec  in  1  record/pause-toggle pulse, 1 cycle.
i_key_play  in  1  play/pause-toggle pulse.
i_key_stop  in  1  stop pulse.
i_key_slot  in  1  select next slot pulse.
i_loop  in  1  level; 1 = loop playback at end of take.
i_rec_valid  in  1  recorder sample-ready strobe, 1 cycle.
i_rec_data  in  DATA_W  recorder sample, valid with i_rec_valid.
i_play_tick  in  1  DSP sample-consumed strobe, 1 cycle.
i_play_off  in  ADDR_W-SLOT_BITS  DSP read offset within the slot.
o_sram_addr  out  ADDR_W  registered SRAM address.
o_sram_wdata  out  DATA_W  registered write data.
o_sram_we_n  out  1  write strobe, active low.
o_sram_oe_n  out  1  output enable, active low.
o_rec_start / o_rec_pause / o_rec_stop  out  1 each  recorder controls, one-hot.
o_dsp_start / o_dsp_pause / o_dsp_stop  out  1 each  DSP controls, one-hot.
o_dsp_restart  out  1  1-cycle pulse that rewinds the DSP to offset 0.
o_slot  out  SLOT_BITS  selected slot.
o_slot_full  out  1  selected slot length == SLOT_DEPTH.
o_state  out  3  encoded FSM state.
o_rec_time  out  TIME_W  recorded seconds.
o_play_time  out  TIME_W  played seconds.

Behaviour:
- SLOT_BITS = max(1, clog2(NUM_SLOTS)). SLOT_DEPTH = 2^(ADDR_W-SLOT_BITS). Slot base = slot << (ADDR_W-SLOT_BITS).
- States and encodings: INIT=0, IDLE=1, RECD=2, RECD_PAUSE=3, PLAY=4, PLAY_PAUSE=5. Unused encodings go to IDLE.
- Reset values:
  - state INIT, slot 0, all lengths 0, write pointer 0, counters and prescalers 0.
  - o_sram_addr 0, o_sram_wdata 0, o_sram_we_n 1, o_sram_oe_n 1.
  - o_rec_stop=1, o_dsp_stop=1, all other controls 0.
- Reset mid-operation aborts immediately; a recorded length that is lost is acceptable.
- Key priority within a cycle: stop > rec > play > slot. Only the highest-priority key is acted on.
- INIT:
  - Move to IDLE on i_i2c_done; all keys are ignored until then.
- IDLE:
  - rec: clear the write pointer and the slot's length to 0, go to RECD.
  - play: go to PLAY only if the slot length is non-zero, else stay in IDLE. Play-time counter cleared.
  - slot: slot = slot+1 mod NUM_SLOTS. Slot changes are accepted only in IDLE.
- RECD:
  - rec goes to RECD_PAUSE; stop goes to IDLE.
  - Each i_rec_valid: write at base+ptr, increment ptr, set length = ptr+1.
  - When length reaches SLOT_DEPTH: go to IDLE on the next cycle and ignore further strobes.
- RECD_PAUSE:
  - rec goes to RECD with the pointer preserved; stop goes to IDLE.
  - i_rec_valid is ignored.
- PLAY:
  - play goes to PLAY_PAUSE; stop goes to IDLE.
  - End of take is i_play_off >= length.
  - End of take with i_loop=1: pulse o_dsp_restart for 1 cycle, clear the play-time counter and prescaler, stay in PLAY.
  - End of take with i_loop=0: go to IDLE.
- PLAY_PAUSE:
  - play goes to PLAY; stop goes to IDLE.
- Control outputs are decoded combinationally from state:
  - o_rec_start in RECD; o_rec_pause in RECD_PAUSE; o_rec_stop otherwise.
  - The o_dsp_* outputs are decoded the same way from PLAY / PLAY_PAUSE.
- SRAM interface, registered with 1-cycle latency:
  - Cycle after an accepted i_rec_valid: o_sram_we_n=0 for exactly 1 cycle, o_sram_addr=base+ptr (pre-increment), o_sram_wdata=i_rec_data, o_sram_oe_n=1.
  - Otherwise in PLAY or PLAY_PAUSE: o_sram_addr=base+i_play_off, o_sram_we_n=1, o_sram_oe_n=0.
  - In INIT, IDLE and RECD_PAUSE: o_sram_we_n=1, o_sram_oe_n=1, address holds.
- Time counters:
  - Record: a prescaler counts accepted i_rec_valid in RECD. At SAMPLES_PER_SEC-1 it wraps to 0 and o_rec_time increments, saturating at 2^TIME_W-1.
  - Play: the same scheme using i_play_tick in PLAY.
  - Both counters hold while paused.
  - o_rec_time clears on entry to RECD from IDLE; o_play_time clears on entry to PLAY from IDLE. Both hold in IDLE for display.
- Simultaneous events:
  - Stop together with slot-full or end-of-take: go to IDLE, with no restart pulse.
  - rec together with i_rec_valid in RECD: the sample is written, then the block pauses.

Decomposition:
- Package aud_pkg holds state_t, its encodings, and the SLOT_BITS/SLOT_DEPTH helper functions.
- Sub-module aud_sec_counter is instantiated twice (record and play). Ports: tick, enable, clear, prescaler terminal count, saturating TIME_W output.

Test Plan:
- Reset, then i_i2c_done after 10 cycles: state 0→1; o_rec_stop=1, o_dsp_stop=1, o_sram_we_n=1.
- Slot 2 (NUM_SLOTS=4, ADDR_W=20): key_slot×2, key_rec, 5 strobes with data 0x0001..0x0005 → five writes at 0x80000..0x80004 one cycle after each strobe, we_n low for 1 cycle each; key_stop → length 5.
- Playback of that take: key_play, i_play_off stepped 0..5 with i_loop=0 → address 0x80000+off; at off=5 state returns to IDLE.
- Same playback with i_loop=1: at off=5, o_dsp_restart pulses 1 cycle, o_play_time clears, state stays 4.
- Full slot (ADDR_W=6, NUM_SLOTS=4, depth 16): 20 strobes → exactly 16 writes, o_slot_full=1, state IDLE; key_rec+key_stop in the same cycle during RECD → IDLE.
- Timers (SAMPLES_PER_SEC=4, TIME_W=3): 40 strobes in RECD with a pause mid-run → o_rec_time saturates at 7 and holds while paused; key_play on an empty slot → state stays IDLE.
